// File: rtl/guess_pkg.sv
// Shared definitions for the guess game: button count and arbiter/FSM state encoding.
package guess_pkg;

    localparam int NUM_BTN = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FIRE = 2'd1,
        WAIT = 2'd2
    } guess_state_t;

    // True when exactly one button is down; zero is not one-hot.
    function automatic logic is_one_hot(input logic [NUM_BTN-1:0] value);
        return (value != '0) && ((value & (value - 1'b1)) == '0);
    endfunction

endpackage

// File: rtl/guess_input_conditioner_debounce_bit.sv
// One pushbutton: two-flop synchronizer followed by a counter debouncer.
module debounce_bit #(
    parameter int N = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    localparam logic [N-1:0] COUNT_ONE = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0] COUNT_MAX = '1;

    logic          sync_a;
    logic          sync_b;
    logic          stable;
    logic [N-1:0]  count;

    // The counter only advances while the synchronized input disagrees with
    // the stable value; any agreement restarts the whole 2^N window.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            stable <= 1'b0;
            count  <= '0;
        end else begin
            sync_a <= din;
            sync_b <= sync_a;
            if (sync_b == stable) begin
                count <= '0;
            end else if (count == COUNT_MAX) begin
                stable <= sync_b;
                count  <= '0;
            end else begin
                count <= count + COUNT_ONE;
            end
        end
    end

    assign dout = stable;

endmodule

// File: rtl/guess_input_conditioner.sv
// Debounces four guess buttons and turns a single clean press into one
// registered pulse; multi-button presses are rejected instead.
module guess_input_conditioner
    import guess_pkg::*;
#(
    parameter int N = 20
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_BTN-1:0]  btn_raw,
    output logic                b0,
    output logic                b1,
    output logic                b2,
    output logic                b3,
    output logic                reject
);

    logic [NUM_BTN-1:0] stable;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_debounce
        debounce_bit #(.N(N)) u_debounce (
            .clk   (clk),
            .reset (reset),
            .din   (btn_raw[i]),
            .dout  (stable[i])
        );
    end

    guess_state_t       state;
    guess_state_t       next_state;
    logic [NUM_BTN-1:0] fire_code;
    logic [NUM_BTN-1:0] next_fire_code;
    logic               reject_q;
    logic               next_reject;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            fire_code <= '0;
            reject_q  <= 1'b0;
        end else begin
            state     <= next_state;
            fire_code <= next_fire_code;
            reject_q  <= next_reject;
        end
    end

    // Outputs are computed for the state being entered so that the pulse
    // register is high exactly while the arbiter sits in FIRE.
    always_comb begin
        next_state     = state;
        next_fire_code = '0;
        next_reject    = 1'b0;
        case (state)
            IDLE: begin
                if (stable == '0) begin
                    next_state = IDLE;
                end else if (is_one_hot(stable)) begin
                    next_state     = FIRE;
                    next_fire_code = stable;
                end else begin
                    next_state  = WAIT;
                    next_reject = 1'b1;
                end
            end
            FIRE: begin
                next_state = WAIT;
            end
            WAIT: begin
                if (stable == '0) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign b0     = fire_code[0];
    assign b1     = fire_code[1];
    assign b2     = fire_code[2];
    assign b3     = fire_code[3];
    assign reject = reject_q;

endmodule
